// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA configuration path.
//   cfg_ldr_state_t     : context loader FSM states
//   CFG_WORD_W          : default config word width
//   CFG_TIMEOUT_DEFAULT : default per-word grant/response timeout in cycles
package cgra_pkg;

    localparam int unsigned CFG_WORD_W          = 32;
    localparam int unsigned CFG_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRsp,
        StDone,
        StError
    } cfg_ldr_state_t;

endpackage

// File: rtl/cgra_cfg_chksum.sv
// XOR accumulator for context integrity checking.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the accumulation (new load)
//   acc_en     : fold data into the running XOR
//   data       : current response word
//   match      : running XOR equals data (used when data is the check word)
module cgra_cfg_chksum
    import cgra_pkg::*;
#(
    parameter int unsigned DATA_W = CFG_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] data,
    output logic              match
);

    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q ^ data;
        end
    end

    assign match = (acc_q == data);

endmodule

// File: rtl/cgra_cfg_loader.sv
// Double-buffered CGRA context loader.
// Fetches one context (NUM_PES*WORDS_PER_PE words) over a single-outstanding read port on the
// rising edge of cfg_load_start and writes it into the shadow PE config bank. A swap pulse
// flips the active bank once the shadow bank holds a complete context.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_load_start        : level request; rising edge starts a load
//   cfg_base_addr         : context base address, sampled on the start edge
//   cfg_swap_buffers      : one-cycle swap pulse
//   cfg_load_done         : one-cycle completion pulse
//   cfg_load_error        : error flag, held until the next start edge
//   context_active_buf    : active bank
//   shadow_valid          : shadow bank holds a complete context
//   mem_req/addr/gnt      : read request channel
//   mem_rvalid/rdata/rerr : read response channel
//   pe_cfg_we/bank/addr/data : PE config write port (bank is always the shadow bank)
// Build option: CGRA_CFG_CHECKSUM_EN appends an XOR check word to each context.
module cgra_cfg_loader
    import cgra_pkg::*;
#(
    parameter int unsigned NUM_PES        = 16,
    parameter int unsigned WORDS_PER_PE   = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = CFG_WORD_W,
    parameter int unsigned TIMEOUT_CYCLES = CFG_TIMEOUT_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_load_start,
    input  logic [ADDR_W-1:0]                       cfg_base_addr,
    input  logic                                    cfg_swap_buffers,
    output logic                                    cfg_load_done,
    output logic                                    cfg_load_error,
    output logic                                    context_active_buf,
    output logic                                    shadow_valid,
    output logic                                    mem_req,
    output logic [ADDR_W-1:0]                       mem_addr,
    input  logic                                    mem_gnt,
    input  logic                                    mem_rvalid,
    input  logic [DATA_W-1:0]                       mem_rdata,
    input  logic                                    mem_rerr,
    output logic                                    pe_cfg_we,
    output logic                                    pe_cfg_bank,
    output logic [$clog2(NUM_PES*WORDS_PER_PE)-1:0] pe_cfg_addr,
    output logic [DATA_W-1:0]                       pe_cfg_data
);

    localparam int unsigned TOTAL = NUM_PES * WORDS_PER_PE;
    localparam int unsigned PE_AW = $clog2(TOTAL);
`ifdef CGRA_CFG_CHECKSUM_EN
    localparam int unsigned NUM_WORDS = TOTAL + 1;
`else
    localparam int unsigned NUM_WORDS = TOTAL;
`endif
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    cfg_ldr_state_t state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              active_q, active_d;
    logic              sv_q, sv_d;
    logic              we_q, we_d;
    logic [PE_AW-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic start_edge;
    logic load_go;
    logic last_word;
    logic tmo_hit;
    logic wr;

    assign start_edge = cfg_load_start & ~start_q;
    assign load_go    = start_edge & ((state_q == StIdle) | (state_q == StError));
    assign last_word  = (idx_q == IDX_W'(NUM_WORDS - 1));
    assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

`ifdef CGRA_CFG_CHECKSUM_EN
    logic chk_match;

    // Only data words are folded in; the final (check) word is compared against the sum.
    cgra_cfg_chksum #(
        .DATA_W (DATA_W)
    ) u_chksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load_go),
        .acc_en (state_q == StRsp && mem_rvalid && !mem_rerr && !last_word),
        .data   (mem_rdata),
        .match  (chk_match)
    );
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        idx_d    = idx_q;
        active_d = active_q;
        sv_d     = sv_q;
        wr       = 1'b0;

        // Swap is evaluated before the load start so a same-cycle start targets the new shadow.
        if (cfg_swap_buffers && sv_q) begin
            active_d = ~active_q;
            sv_d     = 1'b0;
        end

        unique case (state_q)
            StIdle, StError: begin
                if (load_go) begin
                    base_d  = cfg_base_addr;
                    idx_d   = '0;
                    sv_d    = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d = StRsp;
                end else if (tmo_hit) begin
                    state_d = StError;
                end
            end
            StRsp: begin
                if (mem_rvalid) begin
                    if (mem_rerr) begin
                        state_d = StError;
                    end else if (last_word) begin
`ifdef CGRA_CFG_CHECKSUM_EN
                        state_d = chk_match ? StDone : StError;
`else
                        wr      = 1'b1;
                        state_d = StDone;
`endif
                    end else begin
                        wr      = 1'b1;
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StReq;
                    end
                end else if (tmo_hit) begin
                    state_d = StError;
                end
            end
            StDone: begin
                sv_d    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Per-word timeout counter restarts whenever the state changes.
        if ((state_q == StReq || state_q == StRsp) && state_d == state_q) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end

        we_d    = wr;
        waddr_d = wr ? PE_AW'(idx_q) : waddr_q;
        wdata_d = wr ? mem_rdata : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            base_q   <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            active_q <= 1'b0;
            sv_q     <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= cfg_load_start;
            base_q   <= base_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            active_q <= active_d;
            sv_q     <= sv_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_req            = (state_q == StReq);
    assign mem_addr           = mem_req ? (base_q + ADDR_W'(idx_q) * STRIDE) : '0;
    assign cfg_load_done      = (state_q == StDone);
    assign cfg_load_error     = (state_q == StError);
    assign context_active_buf = active_q;
    assign shadow_valid       = sv_q;
    assign pe_cfg_we          = we_q;
    assign pe_cfg_bank        = ~active_q;
    assign pe_cfg_addr        = waddr_q;
    assign pe_cfg_data        = wdata_q;

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Directed bench for cgra_cfg_loader with NUM_PES=2, WORDS_PER_PE=2, TIMEOUT_CYCLES=8.
// A small memory model grants immediately (when enabled) and answers one cycle after grant.
module tb_cgra_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_load_start;
    logic [31:0] cfg_base_addr;
    logic        cfg_swap_buffers;
    logic        cfg_load_done;
    logic        cfg_load_error;
    logic        context_active_buf;
    logic        shadow_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rerr;
    logic        pe_cfg_we;
    logic        pe_cfg_bank;
    logic [1:0]  pe_cfg_addr;
    logic [31:0] pe_cfg_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cgra_cfg_loader #(
        .NUM_PES        (2),
        .WORDS_PER_PE   (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_load_start     (cfg_load_start),
        .cfg_base_addr      (cfg_base_addr),
        .cfg_swap_buffers   (cfg_swap_buffers),
        .cfg_load_done      (cfg_load_done),
        .cfg_load_error     (cfg_load_error),
        .context_active_buf (context_active_buf),
        .shadow_valid       (shadow_valid),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_gnt            (mem_gnt),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata),
        .mem_rerr           (mem_rerr),
        .pe_cfg_we          (pe_cfg_we),
        .pe_cfg_bank        (pe_cfg_bank),
        .pe_cfg_addr        (pe_cfg_addr),
        .pe_cfg_data        (pe_cfg_data)
    );

    // Memory model
    logic        gnt_en = 1'b1;
    int          err_idx = -1;
    logic [31:0] mem_words [8];

    assign mem_gnt = mem_req & gnt_en;

    always @(posedge clk) begin
        mem_rvalid <= mem_req & mem_gnt;
        mem_rdata  <= mem_words[mem_addr[4:2]];
        mem_rerr   <= mem_req & mem_gnt & (int'(mem_addr[4:2]) == err_idx);
    end

    // Monitor, sampled on the falling edge
    int          wr_cnt, req_cnt, acc_cnt, done_cnt, last_with_done;
    logic [1:0]  wr_addr [16];
    logic [31:0] wr_data [16];
    logic        wr_bank [16];
    logic [31:0] acc_addr [16];

    always @(negedge clk) begin
        if (mem_req) req_cnt++;
        if (cfg_load_done) done_cnt++;
        if (pe_cfg_we && cfg_load_done) last_with_done++;
        if (mem_req && mem_gnt && acc_cnt < 16) begin
            acc_addr[acc_cnt] = mem_addr;
            acc_cnt++;
        end
        if (pe_cfg_we && wr_cnt < 16) begin
            wr_addr[wr_cnt] = pe_cfg_addr;
            wr_data[wr_cnt] = pe_cfg_data;
            wr_bank[wr_cnt] = pe_cfg_bank;
            wr_cnt++;
        end
    end

    task automatic clear_logs();
        wr_cnt = 0; req_cnt = 0; acc_cnt = 0; done_cnt = 0; last_with_done = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Produces a start edge and waits (bounded) for done or error. Cycle n is the n-th
    // falling edge after the rising clock edge that sees the start edge.
    task automatic run_load(input logic [31:0] base, output int done_at, output int err_at,
                            output logic req1);
        cfg_base_addr = base;
        @(negedge clk) cfg_load_start = 1'b0;
        @(negedge clk);
        clear_logs();
        cfg_load_start = 1'b1;
        done_at = -1;
        err_at  = -1;
        req1    = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) req1 = mem_req;
            if (cfg_load_done) done_at = n;
            if (cfg_load_error) err_at = n;
            if (done_at >= 0 || err_at >= 0) break;
        end
        @(negedge clk);  // let the monitor settle
    endtask

    int   done_at, err_at;
    logic req1;

    initial begin
        rst_n = 1'b0;
        cfg_load_start = 1'b0;
        cfg_base_addr = 32'h0;
        cfg_swap_buffers = 1'b0;
        for (int i = 0; i < 8; i++) mem_words[i] = 32'hA0 + i;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_done", {31'b0, cfg_load_done}, 0);
        check("rst_error", {31'b0, cfg_load_error}, 0);
        check("rst_active", {31'b0, context_active_buf}, 0);
        check("rst_shadow", {31'b0, shadow_valid}, 0);
        check("rst_req", {31'b0, mem_req}, 0);
        check("rst_we", {31'b0, pe_cfg_we}, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef CGRA_CFG_CHECKSUM_EN
        // Basic load
        run_load(32'h1000, done_at, err_at, req1);
        check("basic_req_lat", {31'b0, req1}, 1);
        check("basic_done_cyc", done_at, 9);
        check("basic_err", err_at, -1);
        check("basic_wr_cnt", wr_cnt, 4);
        check("basic_acc_cnt", acc_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_mem_addr%0d", i), acc_addr[i], 32'h1000 + 4 * i);
            check($sformatf("basic_wr_addr%0d", i), {30'b0, wr_addr[i]}, i);
            check($sformatf("basic_wr_data%0d", i), wr_data[i], 32'hA0 + i);
            check($sformatf("basic_wr_bank%0d", i), {31'b0, wr_bank[i]}, 1);
        end
        check("basic_last_with_done", last_with_done, 1);
        check("basic_done_once", done_cnt, 1);
        check("basic_shadow", {31'b0, shadow_valid}, 1);

        // Swap, then a swap with nothing loaded
        @(negedge clk) cfg_swap_buffers = 1'b1;
        @(negedge clk) cfg_swap_buffers = 1'b0;
        check("swap_active", {31'b0, context_active_buf}, 1);
        check("swap_shadow", {31'b0, shadow_valid}, 0);
        @(negedge clk) cfg_swap_buffers = 1'b1;
        @(negedge clk) cfg_swap_buffers = 1'b0;
        check("swap2_active", {31'b0, context_active_buf}, 1);

        // Start still held high: no reload
        clear_logs();
        repeat (20) @(negedge clk);
        check("held_no_req", req_cnt, 0);
        check("held_no_done", done_cnt, 0);

        // New rising edge reloads into bank 0
        run_load(32'h1000, done_at, err_at, req1);
        check("reload_done_cyc", done_at, 9);
        check("reload_wr_cnt", wr_cnt, 4);
        check("reload_bank0", {31'b0, wr_bank[0]}, 0);
        check("reload_bank3", {31'b0, wr_bank[3]}, 0);

        // Response error on word 2
        err_idx = 2;
        run_load(32'h1000, done_at, err_at, req1);
        check("rerr_err_cyc", err_at, 7);
        check("rerr_no_done", done_at, -1);
        check("rerr_wr_cnt", wr_cnt, 2);
        check("rerr_wr_addr1", {30'b0, wr_addr[1]}, 1);
        clear_logs();
        repeat (5) @(negedge clk);
        check("rerr_held", {31'b0, cfg_load_error}, 1);
        check("rerr_quiet_req", req_cnt, 0);
        check("rerr_quiet_we", wr_cnt, 0);
        err_idx = -1;
        run_load(32'h1000, done_at, err_at, req1);
        check("recover_done_cyc", done_at, 9);
        check("recover_err", err_at, -1);
        check("recover_wr_cnt", wr_cnt, 4);
        check("recover_err_clr", {31'b0, cfg_load_error}, 0);

        // Grant withheld: timeout after 8 cycles in REQ
        gnt_en = 1'b0;
        run_load(32'h2000, done_at, err_at, req1);
        check("tmo_err_cyc", err_at, 9);
        check("tmo_req_cycles", req_cnt, 8);
        check("tmo_no_we", wr_cnt, 0);

        // Reset in the middle of a load
        gnt_en = 1'b1;
        @(negedge clk) cfg_load_start = 1'b0;
        @(negedge clk) cfg_load_start = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req", {31'b0, mem_req}, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_we", {31'b0, pe_cfg_we}, 0);
        check("midrst_data", pe_cfg_data, 0);
        check("midrst_active", {31'b0, context_active_buf}, 0);
        check("midrst_shadow", {31'b0, shadow_valid}, 0);
        check("midrst_error", {31'b0, cfg_load_error}, 0);
        rst_n = 1'b1;
        cfg_load_start = 1'b0;
        @(negedge clk);
`else
        // Checksum: data 1,2,4,8 and check word 0xF
        mem_words[0] = 32'h1; mem_words[1] = 32'h2; mem_words[2] = 32'h4;
        mem_words[3] = 32'h8; mem_words[4] = 32'hF;
        run_load(32'h1000, done_at, err_at, req1);
        check("chk_ok_done_cyc", done_at, 11);
        check("chk_ok_err", err_at, -1);
        check("chk_ok_wr_cnt", wr_cnt, 4);
        check("chk_ok_acc_cnt", acc_cnt, 5);
        check("chk_ok_wr_data3", wr_data[3], 32'h8);
        check("chk_ok_shadow", {31'b0, shadow_valid}, 1);
        // Wrong check word 0xE
        mem_words[4] = 32'hE;
        run_load(32'h1000, done_at, err_at, req1);
        check("chk_bad_err_cyc", err_at, 11);
        check("chk_bad_no_done", done_at, -1);
        check("chk_bad_wr_cnt", wr_cnt, 4);
        check("chk_bad_shadow", {31'b0, shadow_valid}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
